// File: rtl/raster_pkg.sv
// Shared definitions for the triangle sequencer: frame sizing, the packed vertex
// type and the fetch FSM state encoding.
package raster_pkg;

  localparam int MAX_TRIS = 8;
  localparam int COORD_W  = 10;
  localparam int VERT_W   = 2 * COORD_W;

  typedef logic [VERT_W-1:0] vertex_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2
  } state_t;

endpackage

// File: rtl/vertex_bank.sv
// Double-buffered MAX_TRIS x 3 vertex store: the fetch side fills the back bank,
// a swap copies it and its valid mask to the front bank that the renderer reads.
module vertex_bank #(
  parameter int MAX_TRIS = raster_pkg::MAX_TRIS,
  parameter int VERT_W   = raster_pkg::VERT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [2:0]          wr_tri_i,
  input  logic [1:0]          wr_vert_i,
  input  logic [VERT_W-1:0]   wr_data_i,
  input  logic                swap_i,
  input  logic [MAX_TRIS-1:0] swap_mask_i,
  input  logic [2:0]          rd_tri_i,
  output logic [VERT_W-1:0]   rd_v0_o,
  output logic [VERT_W-1:0]   rd_v1_o,
  output logic [VERT_W-1:0]   rd_v2_o,
  output logic [MAX_TRIS-1:0] valid_o
);
  import raster_pkg::*;

  logic [VERT_W-1:0]   back_q  [MAX_TRIS][3];
  logic [VERT_W-1:0]   front_q [MAX_TRIS][3];
  logic [MAX_TRIS-1:0] valid_q;

  // Writes and swaps never coincide: writes happen only while fetching, swaps only once ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_TRIS; i++) begin
        for (int j = 0; j < 3; j++) begin
          back_q[i][j]  <= '0;
          front_q[i][j] <= '0;
        end
      end
      valid_q <= '0;
    end else begin
      if (wr_en_i) begin
        back_q[wr_tri_i][wr_vert_i] <= wr_data_i;
      end
      if (swap_i) begin
        front_q <= back_q;
        valid_q <= swap_mask_i;
      end
    end
  end

  assign rd_v0_o = front_q[rd_tri_i][0];
  assign rd_v1_o = front_q[rd_tri_i][1];
  assign rd_v2_o = front_q[rd_tri_i][2];
  assign valid_o = valid_q;

endmodule

// File: rtl/triangle_sequencer.sv
// Per-frame triangle loader: fetches vertices during vertical blanking into a back
// bank and swaps it to the front bank at the start of the next visible frame.
module triangle_sequencer #(
  parameter int MAX_TRIS = raster_pkg::MAX_TRIS,
  parameter int COORD_W  = raster_pkg::COORD_W
) (
  input  logic                 clk_pix,
  input  logic                 rst,
  input  logic                 vblank_start,
  input  logic                 frame_start,
  input  logic [3:0]           tri_count,
  output logic                 mem_req,
  output logic [4:0]           mem_addr,
  input  logic                 mem_ack,
  input  logic [2*COORD_W-1:0] mem_rdata,
  input  logic [2:0]           tri_sel,
  output logic [2*COORD_W-1:0] v0,
  output logic [2*COORD_W-1:0] v1,
  output logic [2*COORD_W-1:0] v2,
  output logic [MAX_TRIS-1:0]  tri_valid,
  output logic                 busy,
  output logic                 overrun
);
  import raster_pkg::*;

  state_t              state_q;
  logic [3:0]          n_q;
  logic [2:0]          t_q;
  logic [1:0]          v_q;
  logic                overrun_q;

  logic [3:0]          n_clamp;
  logic                xfer;
  logic                last_xfer;
  logic                swap;
  logic                start;
  logic [MAX_TRIS-1:0] swap_mask;

  assign n_clamp   = (tri_count > 4'(MAX_TRIS)) ? 4'(MAX_TRIS) : tri_count;
  assign xfer      = (state_q == ST_FETCH) && mem_ack;
  assign last_xfer = xfer && (v_q == 2'd2) && ({1'b0, t_q} == (n_q - 4'd1));
  assign swap      = (state_q == ST_READY) && frame_start;
  // A swap returns to IDLE, so a coincident vblank_start may start the next load at once.
  assign start     = vblank_start && ((state_q == ST_IDLE) || swap);
  assign swap_mask = ~({MAX_TRIS{1'b1}} << n_q);

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      t_q       <= '0;
      v_q       <= '0;
      overrun_q <= 1'b0;
    end else if (start) begin
      n_q     <= n_clamp;
      t_q     <= '0;
      v_q     <= '0;
      state_q <= (n_clamp == 4'd0) ? ST_READY : ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (frame_start) begin
            overrun_q <= 1'b1;
          end
          if (last_xfer) begin
            t_q     <= '0;
            v_q     <= '0;
            state_q <= ST_READY;
          end else if (xfer) begin
            if (v_q == 2'd2) begin
              v_q <= '0;
              t_q <= t_q + 3'd1;
            end else begin
              v_q <= v_q + 2'd1;
            end
          end
        end
        ST_READY: begin
          if (frame_start) begin
            state_q <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req  = (state_q == ST_FETCH);
  assign busy     = (state_q == ST_FETCH);
  assign mem_addr = {t_q, v_q};
  assign overrun  = overrun_q;

  vertex_bank #(
    .MAX_TRIS (MAX_TRIS),
    .VERT_W   (2 * COORD_W)
  ) u_bank (
    .clk_i       (clk_pix),
    .rst_i       (rst),
    .wr_en_i     (xfer),
    .wr_tri_i    (t_q),
    .wr_vert_i   (v_q),
    .wr_data_i   (mem_rdata),
    .swap_i      (swap),
    .swap_mask_i (swap_mask),
    .rd_tri_i    (tri_sel),
    .rd_v0_o     (v0),
    .rd_v1_o     (v1),
    .rd_v2_o     (v2),
    .valid_o     (tri_valid)
  );

endmodule

// File: doc/triangle_sequencer.md
TRIANGLE_SEQUENCER -- requirements
Module: triangle_sequencer

Interface
REQ-001 SHALL have parameter MAX_TRIS, default 8, meaning triangle slots per frame.
REQ-002 SHALL have parameter COORD_W, default 10, meaning bits per screen coordinate.
REQ-003 SHALL have port clk_pix  input  1  pixel clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port vblank_start  input  1  one-cycle pulse on the first blanking line.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse at pixel (0,0).
REQ-007 SHALL have port tri_count  input  4  triangles to load; values above MAX_TRIS clamp to MAX_TRIS.
REQ-008 SHALL have port mem_req  output  1  vertex fetch request.
REQ-009 SHALL have port mem_addr  output  5  {tri_idx[2:0], vert_idx[1:0]}.
REQ-010 SHALL have port mem_ack  input  1  fetch accept; mem_rdata is valid in the same cycle.
REQ-011 SHALL have port mem_rdata  input  20  vertex {y[9:0], x[9:0]}.
REQ-012 SHALL have port tri_sel  input  3  front-bank read index.
REQ-013 SHALL have port v0, v1, v2  output  20 each  front-bank vertices of tri_sel; combinational read.
REQ-014 SHALL have port tri_valid  output  MAX_TRIS  front-bank valid mask.
REQ-015 SHALL have port busy  output  1  high in FETCH.
REQ-016 SHALL have port overrun  output  1  sticky flag: a frame_start occurred while still in FETCH.

Function
REQ-017 SHALL implement states IDLE, FETCH and READY.
REQ-018 SHALL, in IDLE on vblank_start, latch n = clamp(tri_count); if n == 0, go to READY with a zero back mask, else go to FETCH with t = 0, v = 0.
REQ-019 SHALL, in FETCH, hold mem_req = 1 and mem_addr = {t, v}; a transfer is any cycle where mem_req & mem_ack.
REQ-020 SHALL, on each transfer, write mem_rdata into back[t][v]; v steps 0->1->2->0, and t increments when v wraps.
REQ-021 SHALL, on the transfer of (t = n-1, v = 2), deassert mem_req in the next cycle and enter READY.
REQ-022 SHALL, in READY on frame_start, copy the back bank to the front bank, set tri_valid = (1<<n)-1, and return to IDLE; the new data is visible on the cycle after frame_start.
REQ-023 SHALL, on frame_start in IDLE, leave the front bank and tri_valid unchanged.
REQ-024 SHALL, on frame_start in FETCH, set overrun = 1, perform no swap, and continue the fetch; the swap then happens at the next frame_start.
REQ-025 SHALL ignore vblank_start in FETCH or READY, with no restart and no change to n.
REQ-026 SHALL, when vblank_start and frame_start fall in the same cycle, evaluate frame_start first against the current state; vblank_start is then honoured only if the resulting state is IDLE.
REQ-027 SHALL keep mem_addr stable while mem_req = 1 and mem_ack = 0, with no timeout.
REQ-028 SHALL never write the front bank except at a swap.
REQ-029 SHALL make tri_valid bits at or above n zero after a swap.

Reset
REQ-030 SHALL, when rst is high at a clk_pix edge, set: state = IDLE, mem_req = 0, mem_addr = 0, busy = 0, overrun = 0, tri_valid = 0, both banks zero, t = v = n = 0.
REQ-031 SHALL abort a fetch when rst is asserted mid-fetch; mem_req falls on the next cycle and no swap occurs.
REQ-032 SHALL ignore pulses on vblank_start and frame_start that are coincident with rst.

Structure
REQ-033 SHALL define MAX_TRIS, COORD_W, the 20-bit vertex type and the state encoding in shared package raster_pkg.
REQ-034 SHALL place the double-buffered MAX_TRIS x 3 vertex store, with swap and read mux, in one sub-module, vertex_bank.
REQ-035 SHALL be implemented in 120-400 lines of RTL.

Verification
REQ-036 SHALL cover: tri_count = 2, mem_ack always 1, vblank_start -> exactly 6 transfers at addrs 0,1,2,4,5,6; busy low after; swap at next frame_start; tri_valid = 8'b00000011.
REQ-037 SHALL cover: mem_ack random 30%, tri_count = 8 -> all 24 vertices land in the correct slots; mem_addr stable during every stall.
REQ-038 SHALL cover: mem_ack held 0 across a frame_start -> overrun = 1, front bank unchanged; after release, swap at the following frame_start.
REQ-039 SHALL cover: tri_count = 0 -> no mem_req; at frame_start tri_valid = 0.
REQ-040 SHALL cover: tri_count = 12 -> clamps to 8, 24 transfers, tri_valid = 8'hFF.
REQ-041 SHALL cover: rst asserted after 3 transfers -> all outputs zero on the next cycle; a subsequent vblank_start restarts at addr 0.
